// File: rtl/data_feeder_ctrl_if.sv
// Control/handshake bundle between the layer controller, the data_feeder
// datapath and its sequencer (data_feeder_ctrl).
interface data_feeder_ctrl_if #(
    parameter int PARALLEL_IFM = 2,
    parameter int PARALLEL_OFM = 2,
    parameter int MAX_ROWS     = 16
);
    localparam int RW = $clog2(MAX_ROWS) + 1;

    logic                                 start;
    logic [RW-1:0]                        cfg_num_rows;
    logic [PARALLEL_IFM-1:0]              cfg_pifm_mask;
    logic [PARALLEL_OFM-1:0]              cfg_pofm_mask;
    logic [PARALLEL_IFM-1:0]              in_buffer_empty;
    logic [PARALLEL_OFM*PARALLEL_IFM-1:0] wg_buffer_empty;
    logic                                 wg_ds_done;
    logic                                 dm_ds_done;
    logic                                 out_ready;

    logic                                 wg_shifting_start;
    logic                                 dm_parallel_load_en;
    logic                                 in_shifting_start;
    logic                                 processing;
    logic                                 processing_stall;
    logic [PARALLEL_IFM-1:0]              pifm_active;
    logic [PARALLEL_OFM-1:0]              pofm_active;
    logic [RW-1:0]                        row_cnt;
    logic                                 busy;
    logic                                 done;
    logic                                 cfg_err;

    modport slave (
        input  start, cfg_num_rows, cfg_pifm_mask, cfg_pofm_mask,
               in_buffer_empty, wg_buffer_empty, wg_ds_done, dm_ds_done, out_ready,
        output wg_shifting_start, dm_parallel_load_en, in_shifting_start,
               processing, processing_stall, pifm_active, pofm_active,
               row_cnt, busy, done, cfg_err
    );

    modport master (
        output start, cfg_num_rows, cfg_pifm_mask, cfg_pofm_mask,
               in_buffer_empty, wg_buffer_empty, wg_ds_done, dm_ds_done, out_ready,
        input  wg_shifting_start, dm_parallel_load_en, in_shifting_start,
               processing, processing_stall, pifm_active, pofm_active,
               row_cnt, busy, done, cfg_err
    );
endinterface

// File: rtl/data_feeder_ctrl.sv
// Layer sequencer for the data_feeder: waits on weight/input buffers, loads
// weights once, then loads and shifts each vertical row window.
module data_feeder_ctrl #(
    parameter int ROW_WIDTH    = 5,
    parameter int COL_HEIGHT   = 3,
    parameter int PARALLEL_IFM = 2,
    parameter int PARALLEL_OFM = 2,
    parameter int MAX_ROWS     = 16
) (
    input logic              clk,
    input logic              rst,
    data_feeder_ctrl_if.slave bus
);
    localparam int RW = $clog2(MAX_ROWS) + 1;
    localparam int PI = PARALLEL_IFM;
    localparam int PO = PARALLEL_OFM;

    typedef enum logic [2:0] {
        S_IDLE, S_WG_LOAD, S_WG_WAIT, S_DM_LOAD,
        S_DM_START, S_DM_SHIFT, S_ROW_NEXT, S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] num_rows_q, num_rows_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic [PI-1:0] pifm_q, pifm_d;
    logic [PO-1:0] pofm_q, pofm_d;
    logic          err_q, err_d;

    logic wg_start_q, wg_start_d;
    logic load_q, load_d;
    logic shift_q, shift_d;
    logic proc_q, proc_d;
    logic stall_q, stall_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic cerr_q, cerr_d;

    // Weight FIFO (o,i) only matters when both its OFM and IFM lanes are enabled.
    logic [PO*PI-1:0] wg_need;
    for (genvar o = 0; o < PO; o++) begin : g_o
        for (genvar i = 0; i < PI; i++) begin : g_i
            assign wg_need[o*PI+i] = pofm_q[o] & pifm_q[i];
        end
    end

    logic wg_ready, in_ready, bad_cfg, last_row;
    assign wg_ready = ~|(wg_need & bus.wg_buffer_empty);
    assign in_ready = ~|(pifm_q & bus.in_buffer_empty);
    assign bad_cfg  = (bus.cfg_num_rows < RW'(COL_HEIGHT)) ||
                      ~|bus.cfg_pifm_mask || ~|bus.cfg_pofm_mask;
    assign last_row = (row_cnt_q == num_rows_q - RW'(COL_HEIGHT));

    always_comb begin
        state_d    = state_q;
        num_rows_d = num_rows_q;
        row_cnt_d  = row_cnt_q;
        pifm_d     = pifm_q;
        pofm_d     = pofm_q;
        err_d      = err_q;
        wg_start_d = 1'b0;
        load_d     = 1'b0;
        shift_d    = 1'b0;
        done_d     = 1'b0;
        cerr_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    num_rows_d = bus.cfg_num_rows;
                    pifm_d     = bus.cfg_pifm_mask;
                    pofm_d     = bus.cfg_pofm_mask;
                    row_cnt_d  = '0;
                    err_d      = bad_cfg;
                    state_d    = bad_cfg ? S_DONE : S_WG_LOAD;
                end
            end
            S_WG_LOAD: begin
                if (wg_ready) begin
                    wg_start_d = 1'b1;
                    state_d    = S_WG_WAIT;
                end
            end
            S_WG_WAIT: begin
                if (bus.wg_ds_done) state_d = S_DM_LOAD;
            end
            S_DM_LOAD: begin
                if (in_ready) begin
                    load_d  = 1'b1;
                    state_d = S_DM_START;
                end
            end
            S_DM_START: begin
                shift_d = 1'b1;
                state_d = S_DM_SHIFT;
            end
            S_DM_SHIFT: begin
                if (bus.dm_ds_done) state_d = S_ROW_NEXT;
            end
            S_ROW_NEXT: begin
                if (last_row) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                    state_d   = S_DM_LOAD;
                end
            end
            S_DONE: begin
                // A rejected config reports on the way out of DONE; a normal
                // layer already reported when ROW_NEXT chose DONE.
                done_d  = err_q;
                cerr_d  = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        proc_d  = (state_d == S_DM_SHIFT);
        stall_d = proc_d & ~bus.out_ready;
        busy_d  = (state_d != S_IDLE);
        if (state_d == S_IDLE) begin
            pifm_d = '0;
            pofm_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            num_rows_q <= '0;
            row_cnt_q  <= '0;
            pifm_q     <= '0;
            pofm_q     <= '0;
            err_q      <= 1'b0;
            wg_start_q <= 1'b0;
            load_q     <= 1'b0;
            shift_q    <= 1'b0;
            proc_q     <= 1'b0;
            stall_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_rows_q <= num_rows_d;
            row_cnt_q  <= row_cnt_d;
            pifm_q     <= pifm_d;
            pofm_q     <= pofm_d;
            err_q      <= err_d;
            wg_start_q <= wg_start_d;
            load_q     <= load_d;
            shift_q    <= shift_d;
            proc_q     <= proc_d;
            stall_q    <= stall_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cerr_q     <= cerr_d;
        end
    end

    assign bus.wg_shifting_start   = wg_start_q;
    assign bus.dm_parallel_load_en = load_q;
    assign bus.in_shifting_start   = shift_q;
    assign bus.processing          = proc_q;
    assign bus.processing_stall    = stall_q;
    assign bus.pifm_active         = pifm_q;
    assign bus.pofm_active         = pofm_q;
    assign bus.row_cnt             = row_cnt_q;
    assign bus.busy                = busy_q;
    assign bus.done                = done_q;
    assign bus.cfg_err             = cerr_q;
endmodule

// File: tb/tb_data_feeder_ctrl.sv
// Bench for data_feeder_ctrl: table of layer configs plus hand sequences for
// starvation, stall, stray inputs and mid-layer reset.
module tb_data_feeder_ctrl;
    localparam int CH = 3;
    localparam int MR = 16;
    localparam int RW = $clog2(MR) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_feeder_ctrl_if #(.PARALLEL_IFM(2), .PARALLEL_OFM(2), .MAX_ROWS(MR)) bus ();

    data_feeder_ctrl #(
        .ROW_WIDTH(5), .COL_HEIGHT(CH), .PARALLEL_IFM(2), .PARALLEL_OFM(2), .MAX_ROWS(MR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int         nr;
        logic [1:0] pm;
        logic [1:0] om;
        int         loads;
        int         err;
    } vec_t;
    vec_t vecs[7];

    int tests = 0, fails = 0, cur_case = -1;
    int ncyc = 0;
    int n_wg, n_load, n_shift, n_done, n_err, n_stall, bad_stall;
    int t_start, t_busy, t_wg, t_wgd, t_first_load, t_second_load, t_first_shift;
    int t_dmd_first, t_dmd_last, t_done, shift_row;
    int mask_p, mask_o;
    int wd = -1, dd = -1, dm_delay = 5, stall_from = -100;
    bit stall_arm = 0;
    int exp_rows[$];
    int exp_err[$];

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (case %0d): got %0d, want %0d", name, cur_case, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_wg = 0; n_load = 0; n_shift = 0; n_done = 0; n_err = 0; n_stall = 0; bad_stall = 0;
        t_busy = -1; t_wg = -1; t_wgd = -1; t_first_load = -1; t_second_load = -1;
        t_first_shift = -1; t_dmd_first = -1; t_dmd_last = -1; t_done = -1;
        mask_p = -1; mask_o = -1;
    endtask

    // One cycle: sample outputs at negedge, run the datapath responder, drive inputs.
    task automatic step();
        @(negedge clk);
        ncyc++;
        bus.start      = 1'b0;
        bus.wg_ds_done = 1'b0;
        bus.dm_ds_done = 1'b0;
        if (wd > 0) begin
            wd--;
            if (wd == 0) begin bus.wg_ds_done = 1'b1; t_wgd = ncyc; wd = -1; end
        end
        if (dd > 0) begin
            dd--;
            if (dd == 0) begin
                bus.dm_ds_done = 1'b1;
                if (t_dmd_first < 0) t_dmd_first = ncyc;
                t_dmd_last = ncyc;
                dd = -1;
            end
        end
        if (bus.busy && t_busy < 0) begin
            t_busy = ncyc; mask_p = int'(bus.pifm_active); mask_o = int'(bus.pofm_active);
        end
        if (bus.wg_shifting_start) begin n_wg++; t_wg = ncyc; wd = 4; end
        if (bus.dm_parallel_load_en) begin
            n_load++;
            if (n_load == 1) t_first_load = ncyc;
            if (n_load == 2) t_second_load = ncyc;
            if (exp_rows.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_load (case %0d): row_cnt %0d, no window expected", cur_case, bus.row_cnt);
            end else chk("row_cnt_at_load", int'(bus.row_cnt), exp_rows.pop_front());
        end
        if (bus.in_shifting_start) begin
            n_shift++;
            if (t_first_shift < 0) t_first_shift = ncyc;
            shift_row = int'(bus.row_cnt);
            dd = dm_delay;
            if (stall_arm) begin stall_from = ncyc + 1; stall_arm = 0; end
        end
        if (bus.processing_stall) begin
            n_stall++;
            if (!bus.processing || int'(bus.row_cnt) != shift_row) bad_stall++;
        end
        if (bus.cfg_err) n_err++;
        if (bus.done) begin
            n_done++; t_done = ncyc;
            if (exp_err.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done (case %0d): done=1 cfg_err=%0d, none expected", cur_case, bus.cfg_err);
            end else chk("cfg_err_with_done", int'(bus.cfg_err), exp_err.pop_front());
        end
        bus.out_ready = !(ncyc >= stall_from && ncyc < stall_from + 3);
    endtask

    task automatic start_layer(int nr, logic [1:0] pm, logic [1:0] om, int err);
        clear_counts();
        if (err != 0) exp_err.push_back(1);
        else begin
            for (int r = 0; r <= nr - CH; r++) exp_rows.push_back(r);
            exp_err.push_back(0);
        end
        bus.start         = 1'b1;
        bus.cfg_num_rows  = RW'(nr);
        bus.cfg_pifm_mask = pm;
        bus.cfg_pofm_mask = om;
        t_start = ncyc;
    endtask

    task automatic wait_done(int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin step(); k++; end
        chk("done_within_budget", n_done, 1);
        step();
        chk("busy_after_done", int'(bus.busy), 0);
        chk("pifm_after_done", int'(bus.pifm_active), 0);
        chk("pofm_after_done", int'(bus.pofm_active), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{5,  2'b11, 2'b11, 3,  0};
        vecs[1] = '{3,  2'b01, 2'b10, 1,  0};
        vecs[2] = '{8,  2'b10, 2'b01, 6,  0};
        vecs[3] = '{2,  2'b11, 2'b11, 0,  1};
        vecs[4] = '{6,  2'b00, 2'b11, 0,  1};
        vecs[5] = '{6,  2'b11, 2'b00, 0,  1};
        vecs[6] = '{16, 2'b11, 2'b11, 14, 0};

        rst = 1'b1;
        bus.start = 0; bus.cfg_num_rows = '0; bus.cfg_pifm_mask = '0; bus.cfg_pofm_mask = '0;
        bus.in_buffer_empty = '0; bus.wg_buffer_empty = '0;
        bus.wg_ds_done = 0; bus.dm_ds_done = 0; bus.out_ready = 1;
        clear_counts();
        repeat (3) step();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_cfg_err", int'(bus.cfg_err), 0);
        chk("rst_processing", int'(bus.processing), 0);
        chk("rst_pifm", int'(bus.pifm_active), 0);
        chk("rst_pofm", int'(bus.pofm_active), 0);
        chk("rst_row_cnt", int'(bus.row_cnt), 0);
        chk("rst_wg_start", int'(bus.wg_shifting_start), 0);
        rst = 1'b0;

        foreach (vecs[v]) begin
            cur_case = v;
            step();
            start_layer(vecs[v].nr, vecs[v].pm, vecs[v].om, vecs[v].err);
            wait_done(400);
            chk("tbl_busy_latency", t_busy - t_start, 1);
            chk("tbl_pifm_latched", mask_p, int'(vecs[v].pm));
            chk("tbl_pofm_latched", mask_o, int'(vecs[v].om));
            chk("tbl_wg_starts", n_wg, vecs[v].err ? 0 : 1);
            chk("tbl_loads", n_load, vecs[v].loads);
            chk("tbl_shifts", n_shift, vecs[v].loads);
            chk("tbl_cfg_err", n_err, vecs[v].err);
            chk("tbl_rows_left", exp_rows.size(), 0);
            if (vecs[v].err != 0) begin
                chk("tbl_err_done_latency", t_done - t_start, 2);
            end else begin
                chk("tbl_wg_latency", t_wg - t_start, 2);
                chk("tbl_load_after_wgd", t_first_load - t_wgd, 2);
                chk("tbl_shift_after_wgd", t_first_shift - t_wgd, 3);
                chk("tbl_done_after_dmd", t_done - t_dmd_last, 2);
                if (vecs[v].loads >= 2) chk("tbl_next_load_after_dmd", t_second_load - t_dmd_first, 3);
            end
        end

        // Starvation on lane 1 with stray dm_ds_done and start while busy.
        cur_case = 100;
        step();
        bus.in_buffer_empty = 2'b10;
        start_layer(3, 2'b11, 2'b11, 0);
        repeat (16) step();
        chk("starved_no_load", n_load, 0);
        bus.dm_ds_done = 1'b1;
        bus.start = 1'b1; bus.cfg_num_rows = RW'(2); bus.cfg_pifm_mask = 2'b01;
        step();
        chk("stray_start_mask_kept", int'(bus.pifm_active), 3);
        chk("stray_still_busy", int'(bus.busy), 1);
        bus.in_buffer_empty = 2'b00;
        begin
            int last_high;
            last_high = ncyc - 1;
            wait_done(200);
            chk("starve_release_load", t_first_load - last_high, 2);
        end
        chk("starve_loads", n_load, 1);
        chk("stray_no_cfg_err", n_err, 0);

        // Lane 1 empty but masked off: must not block.
        cur_case = 101;
        step();
        bus.in_buffer_empty = 2'b10;
        start_layer(4, 2'b01, 2'b11, 0);
        wait_done(200);
        chk("masked_lane_loads", n_load, 2);
        chk("masked_lane_load_latency", t_first_load - t_wgd, 2);
        bus.in_buffer_empty = 2'b00;

        // Output backpressure for three cycles mid-shift.
        cur_case = 102;
        step();
        dm_delay = 10; stall_arm = 1;
        start_layer(3, 2'b11, 2'b11, 0);
        wait_done(200);
        chk("stall_cycles", n_stall, 3);
        chk("stall_bad_proc_or_row", bad_stall, 0);
        chk("stall_loads", n_load, 1);
        dm_delay = 5; stall_from = -100;

        // Reset during the second window's shift aborts without done.
        cur_case = 103;
        step();
        start_layer(5, 2'b11, 2'b11, 0);
        begin
            int k = 0;
            while (n_shift < 2 && k < 100) begin step(); k++; end
        end
        chk("rst_reached_second_shift", n_shift, 2);
        step();
        rst = 1'b1;
        step();
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_processing", int'(bus.processing), 0);
        chk("midrst_stall", int'(bus.processing_stall), 0);
        chk("midrst_pifm", int'(bus.pifm_active), 0);
        chk("midrst_pofm", int'(bus.pofm_active), 0);
        chk("midrst_row_cnt", int'(bus.row_cnt), 0);
        chk("midrst_done", int'(bus.done), 0);
        rst = 1'b0;
        exp_rows.delete(); exp_err.delete();
        wd = -1; dd = -1; n_done = 0;
        repeat (10) step();
        chk("midrst_no_done", n_done, 0);
        chk("midrst_idle", int'(bus.busy), 0);
        start_layer(5, 2'b11, 2'b11, 0);
        wait_done(200);
        chk("after_rst_loads", n_load, 3);
        chk("after_rst_wg", n_wg, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
